// File: rtl/axi_dmem.sv
// AXI4-Lite word-organised data memory with independent read/write FSMs.
// Define DMEM_DECERR_EN to decode word indices >= MEM_WORDS as DECERR.
module axi_dmem #(
   parameter int AXI_AWIDTH = 12,
   parameter int AXI_DWIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int RD_LAT     = 1
) (
   input  logic                  CLK,
   input  logic                  NRST,
   input  logic [AXI_AWIDTH-1:0] AXI_AWADDR,
   input  logic                  AXI_AWVALID,
   output logic                  AXI_AWREADY,
   input  logic [AXI_DWIDTH-1:0] AXI_WDATA,
   input  logic [3:0]            AXI_WSTRB,
   input  logic                  AXI_WVALID,
   output logic                  AXI_WREADY,
   output logic [1:0]            AXI_BRESP,
   output logic                  AXI_BVALID,
   input  logic                  AXI_BREADY,
   input  logic [AXI_AWIDTH-1:0] AXI_ARADDR,
   input  logic                  AXI_ARVALID,
   output logic                  AXI_ARREADY,
   output logic [AXI_DWIDTH-1:0] AXI_RDATA,
   output logic [1:0]            AXI_RRESP,
   output logic                  AXI_RVALID,
   input  logic                  AXI_RREADY
);

   localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int XW = AXI_AWIDTH - 2;
`ifdef DMEM_DECERR_EN
   localparam bit DECERR = 1'b1;
`else
   localparam bit DECERR = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_WAITW, W_WAITA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [AXI_DWIDTH-1:0] mem [MEM_WORDS];

   function automatic logic [IW-1:0] widx(input logic [XW-1:0] w);
      return IW'(32'(w) % 32'(MEM_WORDS));
   endfunction

   function automatic logic werr(input logic [XW-1:0] w);
      return DECERR && (32'(w) >= 32'(MEM_WORDS));
   endfunction

   logic unused_addr;
   assign unused_addr = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

   w_state_e              w_q, w_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [XW-1:0]         awa_q, awa_d;
   logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  aw_hs, w_hs, commit;
   logic [XW-1:0]         c_word;
   logic [AXI_DWIDTH-1:0] c_data;
   logic [3:0]            c_strb;

   assign aw_hs = AXI_AWVALID && awready_q;
   assign w_hs  = AXI_WVALID && wready_q;

   always_comb begin
      w_d     = w_q;
      awa_d   = awa_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      bresp_d = bresp_q;
      commit  = 1'b0;
      c_word  = AXI_AWADDR[AXI_AWIDTH-1:2];
      c_data  = AXI_WDATA;
      c_strb  = AXI_WSTRB;
      unique case (w_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               w_d    = W_RESP;
            end else if (aw_hs) begin
               awa_d = AXI_AWADDR[AXI_AWIDTH-1:2];
               w_d   = W_WAITW;
            end else if (w_hs) begin
               wdata_d = AXI_WDATA;
               wstrb_d = AXI_WSTRB;
               w_d     = W_WAITA;
            end
         end
         W_WAITW: begin
            c_word = awa_q;
            if (w_hs) begin
               commit = 1'b1;
               w_d    = W_RESP;
            end
         end
         W_WAITA: begin
            c_data = wdata_q;
            c_strb = wstrb_q;
            if (aw_hs) begin
               commit = 1'b1;
               w_d    = W_RESP;
            end
         end
         W_RESP: if (AXI_BREADY) w_d = W_IDLE;
         default: w_d = W_IDLE;
      endcase
      if (commit) bresp_d = werr(c_word) ? 2'b11 : 2'b00;
      awready_d = (w_d == W_IDLE) || (w_d == W_WAITA);
      wready_d  = (w_d == W_IDLE) || (w_d == W_WAITW);
      bvalid_d  = (w_d == W_RESP);
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         w_q       <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         awa_q     <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         w_q       <= w_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         awa_q     <= awa_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   // RAM has no reset; a same-edge read sample sees the pre-write word
   always_ff @(posedge CLK) begin
      if (commit && !werr(c_word)) begin
         for (int i = 0; i < 4; i++) begin
            if (c_strb[i]) mem[widx(c_word)][8*i +: 8] <= c_data[8*i +: 8];
         end
      end
   end

   r_state_e              r_q, r_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [XW-1:0]         ara_q, ara_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  ar_hs, sample;

   assign ar_hs = AXI_ARVALID && arready_q;

   always_comb begin
      r_d     = r_q;
      cnt_d   = cnt_q;
      ara_d   = ara_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      sample  = 1'b0;
      unique case (r_q)
         R_IDLE: begin
            if (ar_hs) begin
               ara_d = AXI_ARADDR[AXI_AWIDTH-1:2];
               cnt_d = 4'(RD_LAT);
               r_d   = R_WAIT;
            end
         end
         R_WAIT: begin
            if (cnt_q == 4'd0) begin
               sample = 1'b1;
               r_d    = R_DATA;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         R_DATA: if (AXI_RREADY) r_d = R_IDLE;
         default: r_d = R_IDLE;
      endcase
      if (sample) begin
         if (werr(ara_q)) begin
            rdata_d = AXI_DWIDTH'(32'hDEADBEEF);
            rresp_d = 2'b11;
         end else begin
            rdata_d = mem[widx(ara_q)];
            rresp_d = 2'b00;
         end
      end
      arready_d = (r_d == R_IDLE);
      rvalid_d  = (r_d == R_DATA);
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_q       <= R_IDLE;
         cnt_q     <= '0;
         ara_q     <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         r_q       <= r_d;
         cnt_q     <= cnt_d;
         ara_q     <= ara_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign AXI_AWREADY = awready_q;
   assign AXI_WREADY  = wready_q;
   assign AXI_BVALID  = bvalid_q;
   assign AXI_BRESP   = bresp_q;
   assign AXI_ARREADY = arready_q;
   assign AXI_RVALID  = rvalid_q;
   assign AXI_RDATA   = rdata_q;
   assign AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_dmem.sv
// Scoreboard bench for axi_dmem: directed stimulus, queued expectations,
// independent monitor popping on B/R handshakes.
module tb_axi_dmem;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int MW  = 16;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [DW-1:0] rdata;

   always #5 clk = ~clk;

   axi_dmem #(
      .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .MEM_WORDS(MW), .RD_LAT(LAT)
   ) dut (
      .CLK(clk), .NRST(rst_n),
      .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
      .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid),
      .AXI_WREADY(wready), .AXI_BRESP(bresp), .AXI_BVALID(bvalid),
      .AXI_BREADY(bready), .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid),
      .AXI_ARREADY(arready), .AXI_RDATA(rdata), .AXI_RRESP(rresp),
      .AXI_RVALID(rvalid), .AXI_RREADY(rready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   int         n_pass = 0;
   int         n_tot = 0;
   logic [1:0] exp_b[$];
   rexp_t      exp_r[$];
   rexp_t      mon_e;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", bresp, exp_b.pop_front());
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
               chk("r_unexpected", 1, 0);
            end else begin
               mon_e = exp_r.pop_front();
               chk("rdata", rdata, mon_e.data);
               chk("rresp", rresp, mon_e.resp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_b();
      int i;
      for (i = 0; i < 20 && !(bvalid && bready); i++) tick();
      if (!(bvalid && bready)) chk("b_timeout", 1, 0);
      else tick();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] r);
      exp_b.push_back(r);
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
         bit ag, wg;
         ag = awvalid && awready;
         wg = wvalid && wready;
         tick();
         if (ag) awvalid = 1'b0;
         if (wg) wvalid = 1'b0;
      end
      if (awvalid || wvalid) begin
         chk("aw_w_timeout", 1, 0);
         awvalid = 1'b0; wvalid = 1'b0;
      end
      chk("b_lat", bvalid, 1);
      wait_b();
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [1:0] r);
      int n;
      exp_r.push_back('{data: d, resp: r});
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 20 && !arready; i++) tick();
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin
         tick();
         n++;
      end
      chk("rd_lat", n, LAT + 1);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; arvalid = 0;
      bready = 1; rready = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outs", {awready, wready, bvalid, bresp, arready,
                         rvalid, rresp, rdata}, 0);
      #1 rst_n = 1'b1;
      chk("rdy_pre_edge", {awready, wready, arready}, 3'b000);
      tick();
      chk("rdy_post_edge", {awready, wready, arready}, 3'b111);

      do_write(12'h010, 32'h11223344, 4'hF, 2'b00);
      do_read(12'h010, 32'h11223344, 2'b00);

      do_write(12'h020, 32'hAABBCCDD, 4'hF, 2'b00);
      do_write(12'h020, 32'h00005500, 4'b0010, 2'b00);
      do_read(12'h020, 32'hAABB55DD, 2'b00);

      // AW first, W three cycles later, B held off by BREADY
      bready = 1'b0;
      exp_b.push_back(2'b00);
      awaddr = 12'h030; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk("awready_waitw", awready, 0);
         chk("wready_waitw", wready, 1);
         if (k == 3) begin
            wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
         end
         tick();
      end
      wvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("bvalid_hold", {bvalid, awready, wready}, 3'b100);
         tick();
      end
      bready = 1'b1;
      tick();
      chk("bvalid_clear", bvalid, 0);
      do_read(12'h030, 32'h12345678, 2'b00);

      // W first, AW later
      exp_b.push_back(2'b00);
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("waita_rdy", {awready, wready}, 2'b10);
      tick();
      awaddr = 12'h034; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("waita_bvalid", bvalid, 1);
      tick();
      do_read(12'h034, 32'hCAFEF00D, 2'b00);

      // read backpressure
      rready = 1'b0;
      exp_r.push_back('{data: 32'h11223344, resp: 2'b00});
      araddr = 12'h010; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 20 && !rvalid; i++) tick();
      for (int k = 0; k < 5; k++) begin
         chk("r_hold", {rvalid, arready, rdata}, {2'b10, 32'h11223344});
         tick();
      end
      rready = 1'b1;
      tick();
      chk("r_clear", {rvalid, arready}, 2'b01);

      // same-edge write commit and read sample of word 8
      do_write(12'h020, 32'h1, 4'hF, 2'b00);
      exp_r.push_back('{data: 32'h1, resp: 2'b00});
      exp_b.push_back(2'b00);
      araddr = 12'h020; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      tick();
      awaddr = 12'h020; wdata = 32'h5; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("same_edge_valids", {bvalid, rvalid}, 2'b11);
      tick();
      tick();
      do_read(12'h020, 32'h5, 2'b00);

      // reset while in W_RESP
      bready = 1'b0;
      awaddr = 12'h038; wdata = 32'h77; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wresp_bvalid", bvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {bvalid, awready, wready, arready}, 4'b0000);
      @(posedge clk);
      #3 rst_n = 1'b1;
      bready = 1'b1;
      chk("rst_rel_rdy", {awready, wready, arready}, 3'b000);
      tick();
      chk("rst_edge_rdy", {awready, wready, arready, bvalid}, 4'b1110);
      do_read(12'h038, 32'h77, 2'b00);

`ifdef DMEM_DECERR_EN
      do_write(12'h004, 32'h4444, 4'hF, 2'b00);
      do_write(12'h044, 32'h99, 4'hF, 2'b11);
      do_read(12'h040, 32'hDEADBEEF, 2'b11);
      do_read(12'h004, 32'h4444, 2'b00);
`else
      do_write(12'h004, 32'h4444, 4'hF, 2'b00);
      do_write(12'h044, 32'h99, 4'hF, 2'b00);
      do_read(12'h004, 32'h99, 2'b00);
`endif

      for (int i = 0; i < 20 && (exp_b.size() + exp_r.size()) != 0; i++)
         tick();
      chk("queues_empty", exp_b.size() + exp_r.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
